// File: rtl/ilv_ram_ctrl.sv
// Turbo-encoder interleaver RAM sequencer: fills a block in natural order, drains it in QPP order.
// Optional build macro ILV_BYPASS_EN adds a 'bypass' input that selects natural drain order.
module ilv_ram_ctrl #(
    parameter int DEPTH = 2396,
    parameter int AW    = 12,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] k_len,
    input  logic [AW-1:0] f1,
    input  logic [AW-1:0] f2,
`ifdef ILV_BYPASS_EN
    input  logic          bypass,
`endif
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dia,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addrb,
    output logic [DW-1:0] ram_dib,
    output logic          ram_web,
    input  logic [DW-1:0] ram_dob
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [AW-1:0] DEPTH_V = AW'(DEPTH);
    localparam logic [AW-1:0] ONE     = AW'(1);

    state_t state, state_nxt;

    logic [AW-1:0] k_reg, f1_reg, f2_reg;
    logic [AW-1:0] wr_cnt, rd_cnt;
    logic [AW-1:0] pi, g, s;

`ifdef ILV_BYPASS_EN
    logic byp_reg;
`else
    localparam logic byp_reg = 1'b0;
`endif

    logic [DW-1:0] buf_data [2];
    logic [1:0]    buf_last;
    logic          head, tail;
    logic [1:0]    buf_cnt;
    logic          inflight, inflight_last;

    logic          k_ok, cfg_ok, accept, pop, issue, head_last;
    logic [1:0]    occ;

    // Both operands are already reduced below m, so one conditional subtract suffices.
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic [AW-1:0] m);
        logic [AW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= {1'b0, m}) ? AW'(sum - {1'b0, m}) : AW'(sum);
    endfunction

    assign k_ok = (k_len != '0) && (k_len <= DEPTH_V);
`ifdef ILV_BYPASS_EN
    assign cfg_ok = k_ok && (bypass || ((f1 < k_len) && (f2 < k_len)));
`else
    assign cfg_ok = k_ok && (f1 < k_len) && (f2 < k_len);
`endif

    assign accept    = (state == FILL) && in_valid;
    assign head_last = buf_last[head];
    assign pop       = (state == DRAIN) && (buf_cnt != 2'd0) && out_ready;

    // A slot freed by this cycle's pop can be refilled immediately, giving one beat per cycle.
    assign occ   = buf_cnt + {1'b0, inflight} - {1'b0, pop};
    assign issue = (state == DRAIN) && (rd_cnt < k_reg) && (occ < 2'd2);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && cfg_ok) state_nxt = SETUP;
            SETUP:   state_nxt = FILL;
            FILL:    if (accept && (wr_cnt == k_reg - ONE)) state_nxt = DRAIN;
            DRAIN:   if (pop && head_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == FILL);
    assign ram_wea   = accept;
    assign ram_addra = accept ? wr_cnt : '0;
    assign ram_dia   = accept ? in_data : '0;
    assign ram_addrb = (state == DRAIN) ? pi : '0;
    assign ram_dib   = '0;
    assign ram_web   = 1'b0;
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_data[head];
    assign out_last  = out_valid && head_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            k_reg   <= '0;
            f1_reg  <= '0;
            f2_reg  <= '0;
`ifdef ILV_BYPASS_EN
            byp_reg <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            done    <= pop && head_last;
            cfg_err <= (state == IDLE) && start && !cfg_ok;
            if ((state == IDLE) && start && cfg_ok) begin
                k_reg  <= k_len;
                f1_reg <= f1;
                f2_reg <= f2;
`ifdef ILV_BYPASS_EN
                byp_reg <= bypass;
`endif
            end
        end
    end

    // Second-order difference recurrence for pi(i) = f1*i + f2*i^2 mod K; bypass degenerates to g=1, s=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            pi     <= '0;
            g      <= '0;
            s      <= '0;
        end else begin
            case (state)
                SETUP: begin
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                    pi     <= '0;
                    g      <= mod_add(byp_reg ? ONE : f1_reg, byp_reg ? '0 : f2_reg, k_reg);
                    s      <= byp_reg ? '0 : mod_add(f2_reg, f2_reg, k_reg);
                end
                FILL: begin
                    if (accept) wr_cnt <= wr_cnt + ONE;
                end
                DRAIN: begin
                    if (issue) begin
                        pi     <= mod_add(pi, g, k_reg);
                        g      <= mod_add(g, s, k_reg);
                        rd_cnt <= rd_cnt + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Two-entry output FIFO fed by the RAM's one-cycle read pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last      <= '0;
            head          <= 1'b0;
            tail          <= 1'b0;
            buf_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rd_cnt == k_reg - ONE);
            if (inflight) begin
                buf_data[tail] <= ram_dob;
                buf_last[tail] <= inflight_last;
                tail           <= ~tail;
            end
            if (pop) head <= ~head;
            buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ilv_ram_ctrl.sv
// Self-checking bench for ilv_ram_ctrl: table of block configurations plus randomized blocks,
// checked against a direct QPP formula model with a behavioural dual-port RAM.
module tb_ilv_ram_ctrl;

    localparam int DEPTH = 2396;
    localparam int AW    = 12;
    localparam int DW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] k_len, f1, f2;
    logic          bypass;
    logic          busy, done, cfg_err;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dia, ram_dib, ram_dob;
    logic          ram_wea, ram_web;

    ilv_ram_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .f1        (f1),
        .f2        (f2),
`ifdef ILV_BYPASS_EN
        .bypass    (bypass),
`endif
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_wea   (ram_wea),
        .ram_addrb (ram_addrb),
        .ram_dib   (ram_dib),
        .ram_web   (ram_web),
        .ram_dob   (ram_dob)
    );

    always #5 clk = ~clk;

    // Registered-output dual-port RAM
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dia;
        ram_dob <= mem[ram_addrb];
    end

    typedef struct {
        int k;
        int f1;
        int f2;
        int stall;
        int dataMode;
        bit byp;
        bit expErr;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] data    [DEPTH];
    logic [DW-1:0] expData [DEPTH];
    int passCount  = 0;
    int checkCount = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v);
        int idx, cyc, j, firstValid;
        bit accepted, stallPrev;
        logic [DW-1:0] heldData;
        longint unsigned kk, a, b, p;

        if (!v.expErr) begin
            for (int i = 0; i < v.k; i++) begin
                case (v.dataMode)
                    0:       data[i] = DW'(i % 4);
                    1:       data[i] = DW'($urandom);
                    default: data[i] = DW'(2);
                endcase
            end
            kk = longint'(v.k);
            a  = longint'(v.f1);
            b  = longint'(v.f2);
            for (longint unsigned i = 0; i < kk; i++) begin
                p = v.byp ? i : (a * i + b * i * i) % kk;
                expData[i] = data[p];
            end
        end

        start  = 1'b1;
        k_len  = AW'(v.k);
        f1     = AW'(v.f1);
        f2     = AW'(v.f2);
        bypass = v.byp;
        @(posedge clk); #1;
        start = 1'b0;
        k_len = '0;
        f1    = '0;
        f2    = '0;

        if (v.expErr) begin
            checkOutput("cfg_err pulse", cfg_err, 1);
            checkOutput("busy on bad cfg", busy, 0);
            @(posedge clk); #1;
            checkOutput("cfg_err clears", cfg_err, 0);
            return;
        end
        checkOutput("busy after start", busy, 1);
        checkOutput("no cfg_err on good cfg", cfg_err, 0);

        // Fill with random in_valid gaps; a stray start in the first cycle must be ignored
        idx = 0;
        cyc = 0;
        while (idx < v.k && cyc < 20 * v.k + 50) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = data[idx];
            start    = (cyc == 0);
            k_len    = AW'(3);
            f1       = AW'(1);
            f2       = AW'(1);
            @(negedge clk);
            accepted = in_valid && in_ready;
            if (accepted)
                checkOutput("write port", {ram_wea, ram_addra, ram_dia}, {1'b1, AW'(idx), data[idx]});
            else if (in_ready)
                checkOutput("no write without valid", ram_wea, 0);
            @(posedge clk); #1;
            if (accepted) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (idx != v.k) checkOutput("fill timeout", idx, v.k);

        j          = 0;
        cyc        = 0;
        firstValid = -1;
        stallPrev  = 1'b0;
        heldData   = '0;
        while (j < v.k && cyc < 20 * v.k + 50) begin
            case (v.stall)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) != 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (stallPrev) checkOutput("stall stable", {out_valid, out_data}, {1'b1, heldData});
            stallPrev = 1'b0;
            if (out_valid) begin
                if (firstValid < 0) firstValid = cyc;
                if (out_ready) begin
                    checkOutput("out_data", out_data, expData[j]);
                    checkOutput("out_last", out_last, (j == v.k - 1));
                    j++;
                end else begin
                    stallPrev = 1'b1;
                    heldData  = out_data;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (j != v.k) checkOutput("drain timeout", j, v.k);
        if (v.stall == 0) begin
            checkOutput("first out_valid latency", firstValid, 2);
            checkOutput("drain cycles", cyc, v.k + 2);
        end
        checkOutput("done pulse", {done, busy, out_valid}, 3'b100);
        @(posedge clk); #1;
        checkOutput("done clears", done, 0);
    endtask

    initial begin
        vec_t r;
        rst_n     = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        f1        = '0;
        f2        = '0;
        bypass    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state",
            {busy, done, cfg_err, in_ready, out_valid, out_last, ram_wea, out_data, ram_addra, ram_dia, ram_addrb}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{40, 3, 10, 0, 0, 1'b0, 1'b0});
        vecs.push_back('{40, 3, 10, 1, 0, 1'b0, 1'b0});
        vecs.push_back('{0, 0, 0, 0, 0, 1'b0, 1'b1});
        vecs.push_back('{2397, 0, 0, 0, 0, 1'b0, 1'b1});
        vecs.push_back('{40, 3, 40, 0, 0, 1'b0, 1'b1});
        vecs.push_back('{40, 40, 3, 0, 0, 1'b0, 1'b1});
        vecs.push_back('{1, 0, 0, 0, 2, 1'b0, 1'b0});
        vecs.push_back('{17, 16, 16, 0, 1, 1'b0, 1'b0});
        vecs.push_back('{DEPTH, 263, 480, 2, 1, 1'b0, 1'b0});
`ifdef ILV_BYPASS_EN
        vecs.push_back('{8, 9, 9, 0, 0, 1'b1, 1'b0});
`endif
        for (int n = 0; n < 4; n++) begin
            r.k        = $urandom_range(2, 200);
            r.f1       = $urandom_range(0, r.k - 1);
            r.f2       = $urandom_range(0, r.k - 1);
            r.stall    = 2;
            r.dataMode = 1;
            r.byp      = 1'b0;
            r.expErr   = 1'b0;
            vecs.push_back(r);
        end

        foreach (vecs[n]) applyStimulus(vecs[n]);

        // Reset in the middle of a fill, then a clean block
        start = 1'b1;
        k_len = AW'(40);
        f1    = AW'(3);
        f2    = AW'(10);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_data = DW'(i);
            @(posedge clk); #1;
        end
        checkOutput("mid-fill position", {busy, ram_addra}, {1'b1, AW'(10)});
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset mid-fill",
            {busy, done, cfg_err, in_ready, out_valid, out_last, ram_wea, out_data, ram_addra, ram_dia, ram_addrb}, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        r = '{40, 3, 10, 0, 1, 1'b0, 1'b0};
        applyStimulus(r);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ilv_ram_ctrl.md
Name: ilv_ram_ctrl

Overview:
- Sequencer for the turbo encoder's 2396 x 2-bit dual-port interleaver RAM.
- Fill: accepts a block of K 2-bit symbols in natural order and writes them through RAM port A.
- Drain: reads the block back through RAM port B in QPP-interleaved order, pi(i) = (f1*i + f2*i^2) mod K.
- Sits between the systematic input stream and the second constituent encoder, with valid/ready handshakes on both sides.

Parameters:
- DEPTH, 2396, RAM entries; upper limit for K.
- AW, 12, RAM address width.
- DW, 2, symbol width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; latches k_len/f1/f2; honoured only in IDLE.
- k_len  in  AW  block length K.
- f1  in  AW  QPP coefficient f1.
- f2  in  AW  QPP coefficient f2.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last output beat is accepted.
- cfg_err  out  1  one-cycle pulse when start carries an illegal configuration.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  high only in FILL.
- in_data  in  DW  input symbol.
- out_valid  out  1  interleaved symbol valid.
- out_ready  in  1  downstream accept.
- out_data  out  DW  interleaved symbol.
- out_last  out  1  high with the final (K-th) output beat.
- ram_addra  out  AW  RAM port A address (write side).
- ram_dia  out  DW  RAM port A write data.
- ram_wea  out  1  RAM port A write enable.
- ram_addrb  out  AW  RAM port B address (read side).
- ram_dib  out  DW  RAM port B write data; tied to 0.
- ram_web  out  1  RAM port B write enable; tied to 0.
- ram_dob  in  DW  RAM port B read data; registered by the RAM, 1-cycle latency.

Behaviour:
- Reset values: busy, done, cfg_err, in_ready, out_valid, out_last, ram_wea = 0; out_data, ram_addra, ram_dia, ram_addrb = 0; state = IDLE; all counters and the output buffer cleared.
- Reset mid-operation aborts the block. RAM contents are not cleared.
- States:
  - IDLE --start, config legal--> SETUP.
  - IDLE --start, config illegal--> IDLE with cfg_err = 1 for one cycle.
  - SETUP (1 cycle) --> FILL.
  - FILL --K-th accepted beat--> DRAIN.
  - DRAIN --K-th output accepted--> IDLE with done = 1.
- Legal configuration: 1 <= k_len <= DEPTH, f1 < k_len, f2 < k_len. k_len, f1 and f2 are latched on start; later input changes are ignored.
- SETUP precomputes, each with one conditional subtract:
  - g0 = (f1+f2) mod K
  - s = (2*f2) mod K
- FILL:
  - in_ready = 1.
  - Each beat with in_valid && in_ready drives combinationally ram_wea = 1, ram_addra = wr_cnt, ram_dia = in_data; wr_cnt then increments.
  - ram_wea = 0 whenever no beat is accepted.
- DRAIN address generator:
  - Starts at pi = 0, g = g0.
  - Per issued read: pi <= (pi+g) mod K, g <= (g+s) mod K.
  - Each modulo is a conditional subtract, since both operands are < K. No multipliers.
- DRAIN flow control:
  - Output is served from an internal 2-entry buffer.
  - A read is issued (ram_addrb = pi) only when buffered entries + reads in flight < 2 and the read count is < K.
  - ram_dob is captured into the buffer 1 cycle after the read is issued.
  - out_valid = buffer non-empty; out_data/out_last come from the buffer head.
  - With out_ready held high: first out_valid 2 cycles after DRAIN entry, then 1 beat/cycle.
  - out_valid/out_data stay stable while out_ready = 0.
- Hazard: the first DRAIN read occurs at the earliest 1 cycle after the last FILL write, so there is no read-during-write on the same address.
- K = 1: single output beat with out_last = 1.
- start during non-IDLE states is ignored.

Optional Feature:
- Macro: ILV_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit), latched with start.
  - When latched high, DRAIN reads natural order (pi(i) = i); f1/f2 are not checked.
- Undefined:
  - Port absent; QPP order always.

Test Plan:
- K=40, f1=3, f2=10, in_data[i] = i mod 4, out_ready = 1 -> read addresses 0, 13, 6, 19, ...; out_data 0, 1, 2, 3, ...; 40 beats; out_last on beat 40; done 1 cycle later.
- Same block with out_ready toggled 1-0-1 -> no lost or duplicated beats, out_data stable while stalled, sequence identical to the previous case.
- start with k_len=0, then k_len=2397, then f2=k_len -> cfg_err pulse each time; busy stays 0.
- K=1, f1=0, f2=0, in_data=2 -> one output beat with out_data=2, out_last=1; done pulse.
- rst_n=0 after 10 FILL beats -> all outputs at reset values next cycle; a new K=40 block afterwards completes correctly.
- ILV_BYPASS_EN build, bypass=1, K=8 -> outputs in natural order 0..7.
